fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end directly upstream of the instruction ROM; owns the program counter and drives the ROM's word address.
- ROM read is combinational, so `imem_rdata` is valid in the same cycle as `imem_addr`.
- Captures each fetched word and its PC into a small in-order queue. Hands the queue to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and stops fetching on an all-zero instruction word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, queue entries; power of two, ≥2.
- HALT_ON_ZERO, 1, when 1 a fetched word of 32'h0 halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction ROM; equals current PC.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  instruction at queue head.
- out_pc  out  32  PC of instruction at queue head.
- redirect_valid  in  1  load new PC and flush queue.
- redirect_pc  in  32  redirect target byte address.
- halted  out  1  fetch stopped on zero word.
- misalign_flag  out  1  sticky: a redirect target had bits [1:0] ≠ 0.

Behaviour:
- Reset, while `reset`=1 at a clock edge:
  - pc=RESET_PC, queue count=0, rd/wr pointers=0.
  - state=RUN, halted=0, misalign_flag=0.
  - out_valid=0. out_instr and out_pc read as 0 when the queue is empty.
  - Reset overrides all other inputs, including mid-operation.
- `imem_addr` = pc, combinational, in every state.
- pop = out_valid & out_ready. out_valid = (count≠0). The head is read combinationally from the queue storage.
- can_push = (count<DEPTH) | pop.
- State RUN, redirect_valid=0, can_push=1:
  - If HALT_ON_ZERO=1 and imem_rdata==0: do not push, do not advance pc, go to HALT.
  - Otherwise: push {pc, imem_rdata} at the write pointer, then pc ← pc+4. PC arithmetic is modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- State RUN, can_push=0: pc holds and no push occurs. No word is dropped or duplicated.
- State HALT:
  - No push; pc holds at the address of the zero word; halted=1.
  - The queue continues to drain through pop.
- Redirect (redirect_valid=1), any state, highest priority after reset:
  - The queue is flushed: count=0, pointers=0. A pop in the same cycle is harmless and has no further effect.
  - pc ← {redirect_pc[31:2], 2'b00}.
  - misalign_flag ← 1 if redirect_pc[1:0] ≠ 0.
  - state ← RUN, halted ← 0.
  - No push occurs in the redirect cycle.
- Count update: +1 on push-only, −1 on pop-only, unchanged when push and pop happen together. Pointers wrap modulo DEPTH.
- Latency:
  - A word fetched at edge N appears at out_valid/out_instr after edge N.
  - After a redirect edge, out_valid=0 for exactly one cycle; the target instruction is valid after the next edge.
- With out_ready held at 1 and no redirect: steady throughput of one instruction per cycle.
- Ordering: out_pc of successive pops increases by 4 except across redirects.

Test Plan:
1. Reset then RUN with out_ready=1, ROM preloaded with a linear program at 0x00..0x24 → one instruction per cycle, out_pc = 0x00, 0x04, 0x08, …, each out_instr matching the ROM word at that address; first out_valid occurs one cycle after reset release.
2. Backpressure: out_ready=0 for 6 cycles from reset, DEPTH=2 → count saturates at 2, imem_addr holds at 0x08. Release out_ready=1 → heads 0x00 and 0x04 are delivered in order, then 0x08, with no gaps or duplicates.
3. Redirect to 0x24 with the queue full → next cycle out_valid=0, imem_addr=0x24; the following cycle out_pc=0x24 with the ROM word at 0x24. Stale entries never appear.
4. Zero word at 0x28 (rest of ROM zero) → after the 0x24 instruction is pushed, halted=1 and imem_addr holds at 0x28. The queue drains, then out_valid=0. Redirect to 0x00 → halted=0 and fetch resumes at 0x00.
5. Misaligned redirect_pc=0x26 → pc=0x24, misalign_flag=1 and it stays 1 through later aligned redirects until reset.
6. Reset asserted mid-stream with the queue full and HALT inactive → after the edge: out_valid=0, imem_addr=RESET_PC, halted=0, misalign_flag=0; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with PC, in-order queue and redirect/halt control
module fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          DEPTH        = 2,
   parameter bit          HALT_ON_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic        misalign_flag
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [0:0]    state_q, state_d;
   logic          mis_q, mis_d;

   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];

   logic          pop;
   logic          can_push;
   logic          fetch_zero;
   logic          fetch_slot;
   logic          push;
   logic          halt_go;

   // Handshake and fetch qualification; a zero word only stops fetch when it could otherwise be pushed
   always_comb begin
      out_valid  = (count_q != '0);
      pop        = out_valid & out_ready;
      can_push   = (count_q < CW'(DEPTH)) | pop;
      fetch_zero = HALT_ON_ZERO && (imem_rdata == 32'h0);
      fetch_slot = !redirect_valid && (state_q == ST_RUN) && can_push;
      push       = fetch_slot && !fetch_zero;
      halt_go    = fetch_slot && fetch_zero;
      imem_addr  = pc_q;
      halted     = (state_q == ST_HALT);
      misalign_flag = mis_q;
      out_instr  = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
      out_pc     = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
   end

   // Next-state: a redirect flushes the queue and wins over any push or pop in the same cycle
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      state_d  = state_q;
      mis_d    = mis_q;
      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         state_d  = ST_RUN;
         mis_d    = mis_q | (redirect_pc[1:0] != 2'b00);
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            pc_d     = pc_q + 32'd4;
         end
         if (halt_go) begin
            state_d = ST_HALT;
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         state_q  <= ST_RUN;
         mis_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         state_q  <= state_d;
         mis_q    <= mis_d;
      end
   end

   // Queue storage; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]    <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

   localparam int DEPTH = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        misalign_flag;

   logic [31:0] rom [256];

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [63:0] m_q[$];
   logic        m_halt;
   logic        m_mis;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_ON_ZERO(1'b1)) dut (
      .clk(clk),
      .reset(reset),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .halted(halted),
      .misalign_flag(misalign_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a < 32'd1024) return rom[a[9:2]];
      return 32'h0;
   endfunction

   always_comb imem_rdata = rom_word(imem_addr);

   function automatic logic [98:0] model_out();
      logic [63:0] h;
      h = (m_q.size() != 0) ? m_q[0] : 64'h0;
      return {m_q.size() != 0, h[63:32], h[31:0], m_pc, m_halt, m_mis};
   endfunction

   function automatic logic [98:0] dut_out();
      return {out_valid, out_pc, out_instr, imem_addr, halted, misalign_flag};
   endfunction

   // Advance the model by one clock edge using the inputs presented at that edge
   task automatic model_update();
      logic [31:0] w;
      bit          room;
      if (reset) begin
         m_q.delete();
         m_pc = RESET_PC;
         m_halt = 1'b0;
         m_mis = 1'b0;
      end else if (redirect_valid) begin
         m_q.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         m_halt = 1'b0;
         if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
         w = rom_word(m_pc);
         room = (m_q.size() < DEPTH) || (m_q.size() != 0 && out_ready);
         if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
         if (!m_halt && room) begin
            if (w == 32'h0) m_halt = 1'b1;
            else begin
               m_q.push_back({m_pc, w});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic load_linear_rom();
      for (int i = 0; i < 256; i++) rom[i] = (i < 10) ? (32'hA000_0000 + 32'(i) * 32'h0101) : 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick(); tick();
      checks++;
      if (dut_out() !== 99'h0) begin
         errors++; $display("FAIL reset_state: got %h expected %h", dut_out(), 99'h0);
      end
      checks++;
      if (dut_out() !== model_out()) begin
         errors++; $display("FAIL reset_model: got %h expected %h", dut_out(), model_out());
      end
   endtask

   task automatic test_linear();
      reset = 1'b1; tick();
      reset = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL linear_not_yet_valid: got %b expected 0", out_valid);
      end
      for (int k = 0; k < 13; k++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            errors++; $display("FAIL linear_model[%0d]: got %h expected %h", k, dut_out(), model_out());
         end
         if (k < 10) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== rom[k]) begin
               errors++; $display("FAIL linear_seq[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                                  k, out_valid, out_pc, out_instr, 32'(4 * k), rom[k]);
            end
         end
      end
      checks++;
      if (halted !== 1'b1 || imem_addr !== 32'h28) begin
         errors++; $display("FAIL linear_end_halt: got h=%b a=%h expected h=1 a=00000028", halted, imem_addr);
      end
   endtask

   task automatic test_backpressure();
      reset = 1'b1; tick();
      reset = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (imem_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++; $display("FAIL bp_full: got a=%h v=%b pc=%h expected a=00000008 v=1 pc=00000000",
                            imem_addr, out_valid, out_pc);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== rom[k]) begin
            errors++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 32'(4 * k));
         end
         checks++;
         if (dut_out() !== model_out()) begin
            errors++; $display("FAIL bp_model[%0d]: got %h expected %h", k, dut_out(), model_out());
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b0;
      tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h24;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h24) begin
         errors++; $display("FAIL redir_bubble: got v=%b a=%h expected v=0 a=00000024", out_valid, imem_addr);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_instr !== rom[9]) begin
         errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h expected v=1 pc=00000024 i=%h",
                            out_valid, out_pc, out_instr, rom[9]);
      end
   endtask

   task automatic test_halt();
      tick();
      checks++;
      if (halted !== 1'b1 || imem_addr !== 32'h28 || out_valid !== 1'b0) begin
         errors++; $display("FAIL halt_enter: got h=%b a=%h v=%b expected h=1 a=00000028 v=0", halted, imem_addr, out_valid);
      end
      tick(); tick();
      checks++;
      if (dut_out() !== model_out() || imem_addr !== 32'h28) begin
         errors++; $display("FAIL halt_hold: got %h expected %h", dut_out(), model_out());
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL halt_resume: got h=%b a=%h expected h=0 a=00000000", halted, imem_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
         errors++; $display("FAIL halt_refetch: got v=%b pc=%h expected v=1 pc=00000000", out_valid, out_pc);
      end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_pc = 32'h26;
      tick();
      checks++;
      if (imem_addr !== 32'h24 || misalign_flag !== 1'b1) begin
         errors++; $display("FAIL misalign_set: got a=%h m=%b expected a=00000024 m=1", imem_addr, misalign_flag);
      end
      redirect_pc = 32'h10;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (imem_addr !== 32'h10 || misalign_flag !== 1'b1) begin
         errors++; $display("FAIL misalign_sticky: got a=%h m=%b expected a=00000010 m=1", imem_addr, misalign_flag);
      end
   endtask

   task automatic test_midreset();
      out_ready = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (out_valid !== 1'b1 || halted !== 1'b0 || out_pc !== 32'h10 || misalign_flag !== 1'b1) begin
         errors++; $display("FAIL midreset_pre: got v=%b h=%b pc=%h m=%b expected v=1 h=0 pc=00000010 m=1",
                            out_valid, halted, out_pc, misalign_flag);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (dut_out() !== {1'b0, 64'h0, RESET_PC, 2'b00}) begin
         errors++; $display("FAIL midreset_state: got %h expected %h", dut_out(), {1'b0, 64'h0, RESET_PC, 2'b00});
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== rom[0]) begin
         errors++; $display("FAIL midreset_restart: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RESET_PC);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom() | 32'h1);
      reset = 1'b1; tick(); reset = 1'b0;
      for (int k = 0; k < 600; k++) begin
         out_ready      = ($urandom_range(0, 9) < 7);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 32'($urandom_range(0, 1023));
         reset          = ($urandom_range(0, 199) == 0);
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            errors++; $display("FAIL random[%0d]: got %h expected %h", k, dut_out(), model_out());
         end
      end
      reset = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      m_pc = RESET_PC; m_halt = 1'b0; m_mis = 1'b0;
      load_linear_rom();
      @(negedge clk);
      test_reset();
      test_linear();
      test_backpressure();
      test_redirect();
      test_halt();
      test_misalign();
      test_midreset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
